// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the multicycle RISC-V control path
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2,
        S_LUI, S_HALT
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SR  = 3'b111;

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        return op == OP_STORE  ? IMM_S :
               op == OP_BRANCH ? IMM_B :
               op == OP_JAL    ? IMM_J :
               op == OP_LUI    ? IMM_U : IMM_I;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: ALU operation from ALUOp and instruction fields; aluflag marks unsigned slt / arithmetic shift
module alu_decoder
    import riscv_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  alu_op_t    alu_op,
    output logic [2:0] alu_control,
    output logic       aluflag
);

    logic [2:0] funct_ctl;

    // funct3-driven operation for R/I-type instructions
    always_comb begin
        funct_ctl = funct3 == 3'b000 ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
                    funct3 == 3'b001 ? ALU_SLL :
                    funct3 == 3'b100 ? ALU_XOR :
                    funct3 == 3'b101 ? ALU_SR  :
                    funct3 == 3'b110 ? ALU_OR  :
                    funct3 == 3'b111 ? ALU_AND : ALU_SLT;
        alu_control = alu_op == ALUOP_ADD ? ALU_ADD :
                      alu_op == ALUOP_SUB ? ALU_SUB : funct_ctl;
        aluflag = (alu_op == ALUOP_FUNCT) & ((funct3 == 3'b011) | ((funct3 == 3'b101) & funct7b5));
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM sequencing the shared multicycle RISC-V datapath
module mc_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       ALUR31,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       aluflag,
    output logic       instr_done,
    output logic       halted
);

    state_t  state_q, state_d;
    alu_op_t alu_op;
    logic    req_c, mw_c, irw_c, pcw_c, rw_c, done_c;
    logic    br_legal, br_taken;

    // beq/bne/blt/bge all have funct3[1]=0; funct3[0] inverts the condition
    assign br_legal = ~funct3[1];
    assign br_taken = (funct3[2] ? ALUR31 : Zero) ^ funct3[0];

    // state register; reset restarts at FETCH
    always_ff @(posedge clk) begin
        state_q <= reset ? S_FETCH : state_d;
    end

    // next-state logic; memory states hold until mem_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = (op == OP_LOAD || op == OP_STORE) ? S_MEMADR :
                                  op == OP_R      ? S_EXEC_R :
                                  op == OP_I      ? S_EXEC_I :
                                  op == OP_BRANCH ? S_BRANCH :
                                  op == OP_JAL    ? S_JAL    :
                                  op == OP_JALR   ? S_JALR   :
                                  op == OP_LUI    ? S_LUI    : S_HALT;
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_MEMWB:    state_d = S_FETCH;
            S_EXEC_R:   state_d = S_ALUWB;
            S_EXEC_I:   state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = br_legal ? S_FETCH : S_HALT;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JALR2;
            S_JALR2:    state_d = S_ALUWB;
            S_LUI:      state_d = S_ALUWB;
            default:    state_d = S_HALT;
        endcase
    end

    // output decode from current state plus handshake and ALU flags
    always_comb begin
        req_c     = 1'b0;
        mw_c      = 1'b0;
        irw_c     = 1'b0;
        pcw_c     = 1'b0;
        rw_c      = 1'b0;
        done_c    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        alu_op    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                req_c     = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                irw_c     = mem_ready;
                pcw_c     = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR, S_JALR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                req_c  = 1'b1;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                rw_c      = 1'b1;
                done_c    = 1'b1;
            end
            S_MEMWRITE: begin
                req_c  = 1'b1;
                mw_c   = 1'b1;
                AdrSrc = 1'b1;
                done_c = mem_ready;
            end
            S_EXEC_R, S_EXEC_I: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = state_q == S_EXEC_I ? SRCB_IMM : SRCB_RD2;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                rw_c   = 1'b1;
                done_c = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_SUB;
                pcw_c   = br_legal & br_taken;
                done_c  = br_legal;
            end
            S_JAL, S_JALR2: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                pcw_c   = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
            end
            default: ;
        endcase
    end

    assign mem_req    = req_c  & ~reset;
    assign MemWrite   = mw_c   & ~reset;
    assign IRWrite    = irw_c  & ~reset;
    assign PCWrite    = pcw_c  & ~reset;
    assign RegWrite   = rw_c   & ~reset;
    assign instr_done = done_c & ~reset;
    assign halted     = (state_q == S_HALT) & ~reset;
    assign ImmSrc     = imm_src(op);

    alu_decoder u_alu_decoder (
        .op5        (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .alu_op     (alu_op),
        .alu_control(ALUControl),
        .aluflag    (aluflag)
    );

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle sequencer for the RISC-V core. A Moore FSM steps one shared datapath (single ALU, single unified memory port, IR/OldPC/ALUOut/Data registers) through fetch, decode, execute, memory and writeback. It replaces the single-cycle control path in the multicycle build. Memory accesses use a req/ready handshake, so wait states stretch the sequence without losing state.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- Zero  in  1  ALU result == 0.
- ALUR31  in  1  ALU result bit 31.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- MemWrite  out  1  request is a store.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC from Result.
- RegWrite  out  1  register file write.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero.
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- ResultSrc  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ImmSrc  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- ALUControl  out  3  from the ALU decoder.
- aluflag  out  1  from the ALU decoder.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- halted  out  1  FSM is in HALT.

## Operation
- ALUOp is internal: 00 = add, 01 = subtract (compare), 10 = decode from funct3/funct7b5. Signals not listed in a state are 0 (mux selects 00).
- ImmSrc is combinational from op:
  - 0100011 → 001 (S)
  - 1100011 → 010 (B)
  - 1101111 → 011 (J)
  - 0110111 → 100 (U)
  - all other opcodes → 000 (I)
- **FETCH**
  - Outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - Holds while mem_ready=0.
  - On mem_ready=1: IRWrite=1, PCWrite=1 (PC ← PC+4), then go to DECODE.
- **DECODE**
  - Outputs: ALUSrcA=01, ALUSrcB=01 (ALUOut ← OldPC+imm).
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - anything else → HALT
- **MEMADR**
  - Outputs: ALUSrcA=10, ALUSrcB=01.
  - Next: MEMREAD if op[5]=0, else MEMWRITE.
- **MEMREAD**
  - Outputs: mem_req=1, AdrSrc=1, ResultSrc=00.
  - Holds until mem_ready, then goes to MEMWB.
- **MEMWB**
  - Outputs: ResultSrc=01, RegWrite=1.
  - Next: FETCH.
- **MEMWRITE**
  - Outputs: mem_req=1, MemWrite=1, AdrSrc=1.
  - Holds until mem_ready, then goes to FETCH.
- **EXEC_R**: ALUSrcA=10, ALUSrcB=00, ALUOp=10; next ALUWB.
- **EXEC_I**: same as EXEC_R but ALUSrcB=01; next ALUWB.
- **ALUWB**: ResultSrc=00, RegWrite=1; next FETCH.
- **BRANCH**
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite = taken, where taken is:
    - funct3 000: Zero
    - funct3 001: !Zero
    - funct3 100: ALUR31
    - funct3 101: !ALUR31
  - Any other funct3 goes to HALT with PCWrite=0; otherwise next is FETCH.
- **JAL**
  - Outputs: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1 (PC ← target; ALUOut ← OldPC+4).
  - Next: ALUWB.
- **JALR**: ALUSrcA=10, ALUSrcB=01 (ALUOut ← rs1+imm); next JALR2.
- **JALR2**: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10; next ALUWB.
- **LUI**: ALUSrcA=11, ALUSrcB=01; next ALUWB.
- **HALT**
  - Sticky until reset.
  - halted=1; all enables and mem_req are 0.
- instr_done=1 in:
  - MEMWB and ALUWB;
  - MEMWRITE when mem_ready=1;
  - BRANCH when not going to HALT.

## Timing
- Reset:
  - While reset=1: state ← FETCH on each edge.
  - mem_req, MemWrite, IRWrite, PCWrite, RegWrite, instr_done and halted are forced 0.
  - First request is in the cycle after reset falls.
- Reset mid-instruction aborts it. No write enable is asserted in the reset cycle.
- Cycle counts with zero wait states (cycles per instruction):
  - R, I, LUI, store, JAL: 4
  - load, JALR: 5
  - branch: 3
- Each wait cycle adds exactly one cycle.
- mem_req, AdrSrc and MemWrite stay stable from request until mem_ready.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- mem_ready asserted in the same cycle as the request completes the access.
- All outputs are decoded from the current state plus mem_ready, Zero, ALUR31 and op. There are no output registers.

## Structure
- Shared package riscv_pkg holds:
  - state enum;
  - opcode constants;
  - ALUSrcA/ALUSrcB/ResultSrc/ImmSrc encodings;
  - ALUOp encodings.
- One sub-module: the existing alu_decoder, instantiated with (op[5], funct3, funct7b5, ALUOp). It drives ALUControl and aluflag.
- The FSM is one state register, one next-state block and one output-decode block.

## Test plan
- **add x3,x1,x2 (0x002081B3), mem_ready=1:**
  - States FETCH → DECODE → EXEC_R → ALUWB.
  - RegWrite=1 only in cycle 4; instr_done in cycle 4.
- **lw (op 0000011), mem_ready low for 2 cycles in MEMREAD:**
  - 7 cycles total; mem_req=1 and AdrSrc=1 held throughout MEMREAD.
  - RegWrite with ResultSrc=01 in the last cycle.
- **Branch pairs:**
  - beq with Zero=1 → PCWrite=1 in BRANCH.
  - bne with Zero=1 → PCWrite=0.
  - blt with ALUR31=1 → PCWrite=1.
  - Each takes 3 cycles.
- **jalr (op 1100111):**
  - PCWrite in JALR2, RegWrite in ALUWB, 5 cycles total.
  - jal: PCWrite in cycle 3, RegWrite in cycle 4.
- **Illegal op 0x7F or branch funct3=110:**
  - Enters HALT, halted=1, no writes for 20 cycles.
  - reset=1 for one cycle → FETCH with mem_req=1 in the next cycle.
- **Reset mid-MEMWRITE while mem_ready=0:**
  - No MemWrite or mem_req in the reset cycle.
  - Restarts at FETCH.
